// File: rtl/alu_4bit_arbiter_if.sv
// Request/response bundle for alu_4bit_arbiter: two requesters
// (valid/ready, a, b, op) and one tagged response channel.
//   master: requesters and response consumer
//   slave : the arbiter
`timescale 1ns/1ps
interface alu_4bit_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zf;
  logic              rsp_sf;
  logic              rsp_of;
  logic              rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result,
    input  rsp_zf, rsp_sf, rsp_of, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result,
    output rsp_zf, rsp_sf, rsp_of, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_4bit_arbiter.sv
// Round-robin arbiter/sequencer in front of an external ALU_4bit.
// Ports: clk, rst (sync, active-high); bus (slave: two request
// channels + tagged response); alu_a/alu_b/alu_op registered to
// the ALU; alu_result/alu_zf/alu_sf/alu_of from the ALU; busy.
// Optional: define ALU_ARB_OPCHK_EN to reject opcode 3'b111
// without touching the ALU (response with rsp_err=1).
`timescale 1ns/1ps
module alu_4bit_arbiter #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  alu_4bit_arbiter_if.slave bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zf,
  input  logic              alu_sf,
  input  logic              alu_of,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            state;
  logic              last_grant;
  logic              id;
  logic              grant;
  logic              ready0;
  logic              ready1;
  logic              accept;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;
  logic              illegal;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zf;
  logic              rsp_sf;
  logic              rsp_of;
`ifdef ALU_ARB_OPCHK_EN
  logic              rsp_err;
`endif

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid)
      grant = ~last_grant;
  end

  assign ready0 = (state == IDLE) & bus.req0_valid & ~grant;
  assign ready1 = (state == IDLE) & bus.req1_valid & grant;
  assign accept = ready0 | ready1;

  assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant ? bus.req1_b  : bus.req0_b;
  assign sel_op = grant ? bus.req1_op : bus.req0_op;

`ifdef ALU_ARB_OPCHK_EN
  assign illegal = (sel_op == '1);
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id         <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zf     <= 1'b0;
      rsp_sf     <= 1'b0;
      rsp_of     <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            id         <= grant;
            if (illegal) begin
              // Illegal op: skip the ALU, answer straight away.
              rsp_valid  <= 1'b1;
              rsp_id     <= grant;
              rsp_result <= '0;
              rsp_zf     <= 1'b0;
              rsp_sf     <= 1'b0;
              rsp_of     <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
              rsp_err    <= 1'b1;
`endif
              state      <= RESP;
            end else begin
              alu_a  <= sel_a;
              alu_b  <= sel_b;
              alu_op <= sel_op;
              state  <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= id;
          rsp_result <= alu_result;
          rsp_zf     <= alu_zf;
          rsp_sf     <= alu_sf;
          rsp_of     <= alu_of;
`ifdef ALU_ARB_OPCHK_EN
          rsp_err    <= 1'b0;
`endif
          state      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_zf     = rsp_zf;
  assign bus.rsp_sf     = rsp_sf;
  assign bus.rsp_of     = rsp_of;
`ifdef ALU_ARB_OPCHK_EN
  assign bus.rsp_err    = rsp_err;
`else
  assign bus.rsp_err    = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_4bit_arbiter.sv
// Directed bench for alu_4bit_arbiter with a behavioural ALU_4bit.
// Vector table for arbitration/results, hand sequences for the rest.
`timescale 1ns/1ps
module tb_alu_4bit_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_zf;
  logic       alu_sf;
  logic       alu_of;
  logic       busy;

  int nvec = 0;
  int nerr = 0;

  alu_4bit_arbiter_if #(.DATA_W(4), .OP_W(3)) bus ();

  alu_4bit_arbiter #(.DATA_W(4), .OP_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zf     (alu_zf),
    .alu_sf     (alu_sf),
    .alu_of     (alu_of),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU_4bit; op 111 returns a fixed marker value.
  always_comb begin
    alu_result = 4'h0;
    alu_of     = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_result = alu_a + alu_b;
        alu_of = (alu_a[3] == alu_b[3]) && (alu_result[3] != alu_a[3]);
      end
      3'b001, 3'b110: begin
        alu_result = alu_a - alu_b;
        alu_of = (alu_a[3] != alu_b[3]) && (alu_result[3] != alu_a[3]);
      end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = {alu_a[3], alu_a[3:1]};
      3'b101: alu_result = {alu_a[2:0], 1'b0};
      default: alu_result = 4'hA;
    endcase
    alu_zf = (alu_result == 4'h0);
    alu_sf = alu_result[3];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       v0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [2:0] op0;
    logic       v1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [2:0] op1;
    logic       id;
    logic [3:0] res;
    logic       zf;
    logic       sf;
    logic       of;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input vec_t v);
    bus.req0_valid = v.v0;
    bus.req0_a     = v.a0;
    bus.req0_b     = v.b0;
    bus.req0_op    = v.op0;
    bus.req1_valid = v.v1;
    bus.req1_a     = v.a1;
    bus.req1_b     = v.b1;
    bus.req1_op    = v.op1;
  endtask

  // Called at a negedge with the DUT in IDLE; leaves it in IDLE.
  task automatic run_txn(input vec_t v, input int idx);
    logic       got;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [2:0] eop;
    got = 1'b0;
    set_req(v);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      chk($sformatf("v%0d ready timeout", idx), 16'd0, 16'd1);
      return;
    end
    chk($sformatf("v%0d grant", idx),
        {bus.req1_ready, bus.req0_ready},
        v.id ? 16'b10 : 16'b01);
    ea  = v.id ? v.a1  : v.a0;
    eb  = v.id ? v.b1  : v.b0;
    eop = v.id ? v.op1 : v.op0;
    @(posedge clk);
    #1;
    if (v.id) bus.req1_valid = 1'b0;
    else      bus.req0_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d exec busy", idx), busy, 1'b1);
    chk($sformatf("v%0d alu_a", idx), alu_a, ea);
    chk($sformatf("v%0d alu_b", idx), alu_b, eb);
    chk($sformatf("v%0d alu_op", idx), alu_op, eop);
    chk($sformatf("v%0d exec rsp_valid", idx), bus.rsp_valid, 1'b0);
    chk($sformatf("v%0d exec ready", idx),
        {bus.req1_ready, bus.req0_ready}, 16'b00);
    @(negedge clk);
    chk($sformatf("v%0d rsp_valid", idx), bus.rsp_valid, 1'b1);
    chk($sformatf("v%0d rsp_id", idx), bus.rsp_id, v.id);
    chk($sformatf("v%0d result", idx), bus.rsp_result, v.res);
    chk($sformatf("v%0d flags", idx),
        {bus.rsp_zf, bus.rsp_sf, bus.rsp_of}, {v.zf, v.sf, v.of});
    chk($sformatf("v%0d rsp_err", idx), bus.rsp_err, 1'b0);
    @(negedge clk);
    chk($sformatf("v%0d rsp drop", idx), bus.rsp_valid, 1'b0);
    chk($sformatf("v%0d idle busy", idx), busy, 1'b0);
  endtask

  initial begin
    vec_t v;
    // both valid: SUB 3,3 vs AND 1100,1010 -> grant 0,1,0,1
    vt[0] = '{1, 4'h3, 4'h3, 3'b001, 1, 4'hC, 4'hA, 3'b010,
              0, 4'h0, 1, 0, 0};
    vt[1] = '{1, 4'h3, 4'h3, 3'b001, 1, 4'hC, 4'hA, 3'b010,
              1, 4'h8, 0, 1, 0};
    vt[2] = vt[0];
    vt[3] = vt[1];
    // single requesters
    vt[4] = '{1, 4'h3, 4'h4, 3'b000, 0, 4'h0, 4'h0, 3'b000,
              0, 4'h7, 0, 0, 0};
    vt[5] = '{0, 4'h0, 4'h0, 3'b000, 1, 4'h7, 4'h7, 3'b000,
              1, 4'hE, 0, 1, 1};
    vt[6] = '{1, 4'h5, 4'h3, 3'b011, 0, 4'h0, 4'h0, 3'b000,
              0, 4'h7, 0, 0, 0};
    vt[7] = '{0, 4'h0, 4'h0, 3'b000, 1, 4'h2, 4'h5, 3'b001,
              1, 4'hD, 0, 1, 0};
    vt[8] = '{1, 4'h8, 4'h1, 3'b001, 0, 4'h0, 4'h0, 3'b000,
              0, 4'h7, 0, 0, 1};
    // tie after req0 won: req1 (OR 0,0) first, then req0 (ADD 8,8)
    vt[9]  = '{1, 4'h8, 4'h8, 3'b000, 1, 4'h0, 4'h0, 3'b011,
               1, 4'h0, 1, 0, 0};
    vt[10] = '{1, 4'h8, 4'h8, 3'b000, 1, 4'h0, 4'h0, 3'b011,
               0, 4'h0, 1, 0, 1};

    // Reset held with a valid request: reset must win.
    rst = 1'b1;
    v = '{1, 4'h9, 4'h6, 3'b010, 0, 4'h0, 4'h0, 3'b000,
          0, 4'h0, 0, 0, 0};
    set_req(v);
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst alu_a", alu_a, 4'h0);
    chk("rst alu_b", alu_b, 4'h0);
    chk("rst alu_op", alu_op, 3'b000);
    chk("rst rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst rsp fields",
        {bus.rsp_id, bus.rsp_result, bus.rsp_zf, bus.rsp_sf,
         bus.rsp_of, bus.rsp_err}, 16'd0);
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_txn(vt[i], i);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Backpressure: hold RESP for 5 cycles with req1 pending.
    bus.rsp_ready = 1'b0;
    v = '{1, 4'h1, 4'h2, 3'b000, 0, 4'h0, 4'h0, 3'b000,
          0, 4'h0, 0, 0, 0};
    set_req(v);
    #1;
    chk("bp ready0", bus.req0_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 4'h4;
    bus.req1_b     = 4'h1;
    bus.req1_op    = 3'b011;
    @(negedge clk);
    chk("bp exec ready1", bus.req1_ready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d rsp_valid", k), bus.rsp_valid, 1'b1);
      chk($sformatf("bp%0d rsp", k),
          {bus.rsp_id, bus.rsp_result, bus.rsp_zf, bus.rsp_sf,
           bus.rsp_of}, {1'b0, 4'h3, 3'b000});
      chk($sformatf("bp%0d ready", k),
          {bus.req1_ready, bus.req0_ready}, 16'b00);
      chk($sformatf("bp%0d busy", k), busy, 1'b1);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release rsp_valid", bus.rsp_valid, 1'b0);
    chk("bp release busy", busy, 1'b0);
    chk("bp pending ready1", bus.req1_ready, 1'b1);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    chk("bp pending busy", busy, 1'b1);
    chk("bp pending alu", {alu_a, alu_b, alu_op},
        {4'h4, 4'h1, 3'b011});
    @(negedge clk);
    chk("bp pending rsp",
        {bus.rsp_valid, bus.rsp_id, bus.rsp_result},
        {1'b1, 1'b1, 4'h5});
    @(negedge clk);
    chk("bp pending drop", bus.rsp_valid, 1'b0);

    // Reset during EXEC of CMP 5,3.
    v = '{1, 4'h5, 4'h3, 3'b110, 0, 4'h0, 4'h0, 3'b000,
          0, 4'h0, 0, 0, 0};
    set_req(v);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("rexec busy", busy, 1'b1);
    chk("rexec alu_a", alu_a, 4'h5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rexec busy after", busy, 1'b0);
    chk("rexec alu after", {alu_a, alu_b, alu_op}, 16'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rexec rsp_valid %0d", k), bus.rsp_valid, 1'b0);
    end
    // last_grant was 0 before reset; reset must put it back to 1.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("rexec tie grant", {bus.req1_ready, bus.req0_ready}, 16'b01);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Reset while holding a response.
    bus.rsp_ready = 1'b0;
    v = '{0, 4'h0, 4'h0, 3'b000, 1, 4'h1, 4'h1, 3'b000,
          1, 4'h0, 0, 0, 0};
    set_req(v);
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rresp rsp_valid", bus.rsp_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    chk("rresp cleared",
        {bus.rsp_valid, bus.rsp_id, bus.rsp_result, busy}, 16'd0);
    @(negedge clk);

    // Opcode 111, preceded by a legal op so alu_* hold known values.
    run_txn(vt[6], 11);
    v = '{1, 4'h6, 4'h9, 3'b111, 0, 4'h0, 4'h0, 3'b000,
          0, 4'h0, 0, 0, 0};
    set_req(v);
    #1;
    chk("op7 ready0", bus.req0_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
`ifdef ALU_ARB_OPCHK_EN
    chk("op7 rsp_valid", bus.rsp_valid, 1'b1);
    chk("op7 rsp_err", bus.rsp_err, 1'b1);
    chk("op7 rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_zf,
        bus.rsp_sf, bus.rsp_of}, 16'd0);
    chk("op7 alu held", {alu_a, alu_b, alu_op},
        {4'h5, 4'h3, 3'b011});
`else
    chk("op7 exec alu", {alu_a, alu_b, alu_op},
        {4'h6, 4'h9, 3'b111});
    chk("op7 exec rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    chk("op7 rsp_valid", bus.rsp_valid, 1'b1);
    chk("op7 rsp_err", bus.rsp_err, 1'b0);
    chk("op7 rsp", {bus.rsp_result, bus.rsp_zf, bus.rsp_sf,
        bus.rsp_of}, {4'hA, 3'b010});
`endif
    @(negedge clk);
    chk("op7 drop", {bus.rsp_valid, busy}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
